stack_cpu_core: RTL

Parametrised multicycle stack-machine core: a single instruction-fetch/data memory port, an internal LIFO operand stack, an ALU and the controller FSM, all in one block. Configurable data width, address width and stack depth. Adds a request/acknowledge memory handshake, a run/idle control and sticky overflow/underflow fault detection. Sits between the top-level testbench/SoC wrapper and an external single-port memory model.

---
 rtl/stack_cpu_pkg.sv | 32 +++
 rtl/stack_cpu_if.sv | 15 +
 rtl/stack_lifo.sv | 43 ++++
 rtl/stack_cpu_core.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_cpu_pkg.sv
// Shared types for the stack CPU: opcode encoding, controller states and fault codes.
package stack_cpu_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpNot  = 3'b011,
        OpPush = 3'b100,
        OpPop  = 3'b101,
        OpJmp  = 3'b110,
        OpJz   = 3'b111
    } opcode_e;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StPopA,
        StPopB,
        StPushRes,
        StMemRd,
        StPushMdr,
        StMemWr,
        StFault
    } state_e;

    localparam logic [1:0] FaultNone      = 2'b00;
    localparam logic [1:0] FaultOverflow  = 2'b01;
    localparam logic [1:0] FaultUnderflow = 2'b10;

endpackage

// File: rtl/stack_cpu_if.sv
// Single-port request/acknowledge memory bus shared by instruction fetch and data accesses.
interface stack_cpu_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/stack_lifo.sv
// Operand stack: DEPTH x DATA_W LIFO with top-of-stack peek and occupancy count.
module stack_lifo
    import stack_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_W-1:0]       i_wdata,
    output logic [DATA_W-1:0]       o_tos,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_count;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_top_idx;

    assign w_wr_idx  = r_count[PTR_W-1:0];
    assign w_top_idx = w_wr_idx - PTR_W'(1);
    assign o_tos     = r_mem[w_top_idx];
    assign o_full    = (r_count == FullCnt);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_wdata;
            r_count         <= r_count + (PTR_W + 1)'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - (PTR_W + 1)'(1);
        end
    end
endmodule

// File: rtl/stack_cpu_core.sv
// Multicycle stack-machine core: controller FSM, operand LIFO, ALU and one memory port.
// Defining STACK_CPU_PERF_EN adds the o_cycle_cnt / o_instr_cnt performance counters.
module stack_cpu_core
    import stack_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_run,
    stack_cpu_if.master             mem,
    output logic [ADDR_W-1:0]       o_pc,
    output logic                    o_busy,
    output logic [1:0]              o_fault,
`ifdef STACK_CPU_PERF_EN
    output logic [31:0]             o_cycle_cnt,
    output logic [31:0]             o_instr_cnt,
`endif
    output logic [$clog2(DEPTH):0]  o_sp
);
    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir, r_a, r_b, r_mdr;
    logic [1:0]        r_fault;
    logic              r_req, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    opcode_e           w_opc;
    logic [ADDR_W-1:0] w_target, w_pc_nxt;
    logic [DATA_W-1:0] w_tos, w_alu, w_push_data;
    logic              w_ack, w_push, w_pop, w_full, w_empty, w_done;

    assign w_opc       = opcode_e'(r_ir[DATA_W-1 -: 3]);
    assign w_target    = r_ir[ADDR_W-1:0];
    assign w_ack       = mem.ack & r_req;
    // Stack ops are suppressed on the faulting access so the stack stays untouched.
    assign w_pop       = (r_state == StPopA || r_state == StPopB) && !w_empty;
    assign w_push      = (r_state == StPushRes || r_state == StPushMdr) && !w_full;
    assign w_push_data = (r_state == StPushMdr) ? r_mdr : w_alu;

    stack_lifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_data),
        .o_tos   (w_tos),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_sp)
    );

    always_comb begin
        case (w_opc)
            OpAdd:   w_alu = r_a + r_b;
            OpSub:   w_alu = r_a - r_b;
            OpNot:   w_alu = ~r_a;
            default: w_alu = r_a & r_b;
        endcase
    end

    // Instruction completion and the pc it leaves behind.
    always_comb begin
        w_done   = 1'b0;
        w_pc_nxt = r_pc;
        case (r_state)
            StDecode: begin
                if (w_opc == OpJmp) begin
                    w_done   = 1'b1;
                    w_pc_nxt = w_target;
                end else if (w_opc == OpJz && !w_empty) begin
                    w_done = 1'b1;
                    if (w_tos == '0) w_pc_nxt = w_target;
                end
            end
            StPushRes, StPushMdr: w_done = !w_full;
            StMemWr:              w_done = w_ack;
            default:              w_done = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_pc    <= '0;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mdr   <= '0;
            r_fault <= FaultNone;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_done) begin
            r_pc    <= w_pc_nxt;
            r_req   <= i_run;
            r_we    <= 1'b0;
            r_addr  <= w_pc_nxt;
            r_state <= i_run ? StFetch : StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_run) begin
                        r_state <= StFetch;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= r_pc;
                    end
                end
                StFetch: begin
                    if (w_ack) begin
                        r_ir    <= mem.rdata;
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_req   <= 1'b0;
                        r_state <= StDecode;
                    end
                end
                StDecode: begin
                    if (w_opc == OpPush) begin
                        r_state <= StMemRd;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= w_target;
                    end else if (w_opc == OpJz) begin
                        r_fault <= FaultUnderflow;
                        r_state <= StFault;
                    end else begin
                        r_state <= StPopA;
                    end
                end
                StPopA: begin
                    if (w_empty) begin
                        r_fault <= FaultUnderflow;
                        r_state <= StFault;
                    end else begin
                        r_a <= w_tos;
                        if (w_opc == OpNot) begin
                            r_state <= StPushRes;
                        end else if (w_opc == OpPop) begin
                            r_state <= StMemWr;
                            r_req   <= 1'b1;
                            r_we    <= 1'b1;
                            r_addr  <= w_target;
                            r_wdata <= w_tos;
                        end else begin
                            r_state <= StPopB;
                        end
                    end
                end
                StPopB: begin
                    if (w_empty) begin
                        r_fault <= FaultUnderflow;
                        r_state <= StFault;
                    end else begin
                        r_b     <= w_tos;
                        r_state <= StPushRes;
                    end
                end
                StPushRes, StPushMdr: begin
                    r_fault <= FaultOverflow;
                    r_state <= StFault;
                end
                StMemRd: begin
                    if (w_ack) begin
                        r_mdr   <= mem.rdata;
                        r_req   <= 1'b0;
                        r_state <= StPushMdr;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign mem.req   = r_req;
    assign mem.we    = r_we;
    assign mem.addr  = r_addr;
    assign mem.wdata = r_wdata;
    assign o_pc      = r_pc;
    assign o_fault   = r_fault;
    assign o_busy    = (r_state != StIdle) && (r_state != StFault);

`ifdef STACK_CPU_PERF_EN
    logic [31:0] r_cycle_cnt, r_instr_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (o_busy) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_done) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_instr_cnt = r_instr_cnt;
`endif
endmodule
